// File: rtl/booth_pkg.sv
// booth_pkg: shared FSM state type and Booth recoding constants for booth_mult_param
package booth_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} booth_state_t;
    // Booth recoding of {Q[0], q_1}: 01 adds M, 10 subtracts M, 00/11 leave acc alone
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;
endpackage

// File: rtl/booth_mult_param_if.sv
// booth_mult_param_if: operand/result handshake bundle for booth_mult_param
// valid/ready/A/B/is_signed: operand request; Mult/done/ack: result handoff
interface booth_mult_param_if #(parameter int WIDTH = 8);
    logic                 valid;
    logic                 ready;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 is_signed;
    logic [2*WIDTH-1:0]   Mult;
    logic                 done;
    logic                 ack;
    modport slave  (input valid, A, B, is_signed, ack, output ready, Mult, done);
    modport master (output valid, A, B, is_signed, ack, input ready, Mult, done);
endinterface

// File: rtl/booth_step.sv
// booth_step: one radix-2 Booth iteration (add/sub of M, then arithmetic shift of {acc, Q, q_1})
// i_acc/i_q/i_q1: current partial state; i_m: extended multiplicand; o_*: state after the step
module booth_step
    import booth_pkg::*;
#(
    parameter int W1 = 9
) (
    input  logic [W1:0]   i_acc,
    input  logic [W1-1:0] i_q,
    input  logic          i_q1,
    input  logic [W1-1:0] i_m,
    output logic [W1:0]   o_acc,
    output logic [W1-1:0] o_q,
    output logic          o_q1
);
    logic [W1:0] w_m;
    logic [1:0]  w_dec;
    logic [W1:0] w_sum;
    // acc is one bit wider than M, so sign-extending M keeps add/sub overflow-free
    assign w_m   = {i_m[W1-1], i_m};
    assign w_dec = {i_q[0], i_q1};
    assign w_sum = (w_dec == BOOTH_ADD) ? i_acc + w_m :
                   (w_dec == BOOTH_SUB) ? i_acc - w_m : i_acc;
    assign o_acc = {w_sum[W1], w_sum[W1:1]};
    assign o_q   = {w_sum[0], i_q[W1-1:1]};
    assign o_q1  = i_q[0];
endmodule

// File: rtl/booth_mult_param.sv
// booth_mult_param: iterative radix-2 Booth multiplier, signed/unsigned, valid/ready in, done/ack out
// clk/rst: clock and sync active-high reset; bus: slave side of booth_mult_param_if
module booth_mult_param
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    booth_mult_param_if.slave    bus
);
    localparam int W1 = WIDTH + 1;
    localparam int CW = $clog2(W1 + 1);
    booth_state_t       r_state;
    logic [W1-1:0]      r_m;
    logic [W1:0]        r_acc;
    logic [W1-1:0]      r_q;
    logic               r_q1;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_mult;
    logic               r_ready;
    logic               r_done;
    logic [W1:0]        w_acc;
    logic [W1-1:0]      w_q;
    logic               w_q1;
    logic [W1-1:0]      w_a_ext;
    logic [W1-1:0]      w_b_ext;
    // One extra bit lets unsigned operands be treated as non-negative signed values
    assign w_a_ext = {bus.is_signed & bus.A[WIDTH-1], bus.A};
    assign w_b_ext = {bus.is_signed & bus.B[WIDTH-1], bus.B};
    booth_step #(.W1(W1)) u_step (
        .i_acc (r_acc),
        .i_q   (r_q),
        .i_q1  (r_q1),
        .i_m   (r_m),
        .o_acc (w_acc),
        .o_q   (w_q),
        .o_q1  (w_q1)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_m     <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_q1    <= 1'b0;
            r_cnt   <= '0;
            r_mult  <= '0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.valid) begin
                    r_m     <= w_a_ext;
                    r_q     <= w_b_ext;
                    r_acc   <= '0;
                    r_q1    <= 1'b0;
                    r_cnt   <= '0;
                    r_ready <= 1'b0;
                    r_state <= CALC;
                end
                CALC: begin
                    r_acc <= w_acc;
                    r_q   <= w_q;
                    r_q1  <= w_q1;
                    r_cnt <= r_cnt + 1'b1;
                    // Last of W1 steps: the low 2*WIDTH bits of {acc, Q} are the exact product
                    if (r_cnt == CW'(W1 - 1)) begin
                        r_mult  <= {w_acc[WIDTH-2:0], w_q};
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: if (bus.ack) begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.ready = r_ready;
    assign bus.done  = r_done;
    assign bus.Mult  = r_mult;
endmodule

// File: tb/tb_booth_mult_param.sv
// tb_booth_mult_param: directed and randomized checks of booth_mult_param at WIDTH=8 and WIDTH=16
module tb_booth_mult_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  booth_mult_param_if #(.WIDTH(8))  bus8 ();
  booth_mult_param_if #(.WIDTH(16)) bus16 ();
  booth_mult_param #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
  booth_mult_param #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic s);
    @(negedge clk);
    chk("ready8_idle", bus8.ready, 1'b1);
    bus8.valid = 1'b1; bus8.A = a; bus8.B = b; bus8.is_signed = s;
    @(negedge clk);
    bus8.valid = 1'b0; bus8.A = 8'h5A; bus8.B = 8'hA5; bus8.is_signed = ~s;
    chk("ready8_busy", bus8.ready, 1'b0);
  endtask
  task automatic wait8(input logic [15:0] exp, input string tag);
    int n = 0;
    while (!bus8.done && n < 40) begin @(negedge clk); n++; end
    chk({tag, "_lat"}, n, 9);
    chk({tag, "_done"}, bus8.done, 1'b1);
    chk(tag, bus8.Mult, exp);
  endtask
  task automatic ack8();
    bus8.ack = 1'b1;
    @(negedge clk);
    bus8.ack = 1'b0;
    chk("done8_clr", bus8.done, 1'b0);
    chk("ready8_ret", bus8.ready, 1'b1);
  endtask
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [15:0] exp, input string tag);
    start8(a, b, s);
    wait8(exp, tag);
    ack8();
  endtask
  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic s,
                       input logic [31:0] exp);
    int n = 0;
    @(negedge clk);
    chk("ready16_idle", bus16.ready, 1'b1);
    bus16.valid = 1'b1; bus16.A = a; bus16.B = b; bus16.is_signed = s;
    @(negedge clk);
    bus16.valid = 1'b0; bus16.A = 16'($urandom); bus16.B = 16'($urandom);
    while (!bus16.done && n < 60) begin @(negedge clk); n++; end
    chk("lat16", n, 17);
    chk("mult16", bus16.Mult, exp);
    bus16.ack = 1'b1;
    @(negedge clk);
    bus16.ack = 1'b0;
    chk("done16_clr", bus16.done, 1'b0);
  endtask
  initial begin
    bus8.valid = 0; bus8.A = 0; bus8.B = 0; bus8.is_signed = 0; bus8.ack = 0;
    bus16.valid = 0; bus16.A = 0; bus16.B = 0; bus16.is_signed = 0; bus16.ack = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready8", bus8.ready, 1'b1);
    chk("rst_done8", bus8.done, 1'b0);
    chk("rst_mult8", bus8.Mult, 16'h0000);
    chk("rst_mult16", bus16.Mult, 32'h0);
    bus8.ack = 1'b1;
    start8(8'd4, 8'd7, 1'b1);
    wait8(16'h001C, "m_4x7");
    @(negedge clk);
    bus8.ack = 1'b0;
    chk("t1_done_clr", bus8.done, 1'b0);
    chk("t1_ready", bus8.ready, 1'b1);
    run8(8'h80, 8'h80, 1'b1, 16'h4000, "m_n128sq");
    run8(8'hFF, 8'h01, 1'b1, 16'hFFFF, "m_n1x1");
    run8(8'h00, 8'hB3, 1'b1, 16'h0000, "m_0xn77");
    run8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "m_u255sq");
    run8(8'hFF, 8'hFF, 1'b1, 16'h0001, "m_s_n1sq");
    run8(8'd200, 8'd3, 1'b0, 16'h0258, "m_u200x3");
    start8(8'd12, 8'd10, 1'b0);
    wait8(16'h0078, "m_12x10");
    for (int i = 0; i < 20; i++) begin
      bus8.valid = i[0]; bus8.A = 8'd9; bus8.B = 8'd9;
      @(negedge clk);
      chk("bp_done", bus8.done, 1'b1);
      chk("bp_mult", bus8.Mult, 16'h0078);
    end
    bus8.valid = 1'b0;
    ack8();
    run8(8'd3, 8'hFE, 1'b1, 16'hFFFA, "m_3xn2");
    start8(8'd100, 8'd100, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_ready", bus8.ready, 1'b1);
    chk("mrst_done", bus8.done, 1'b0);
    chk("mrst_mult", bus8.Mult, 16'h0000);
    run8(8'd3, 8'd5, 1'b0, 16'h000F, "m_3x5");
    run16(16'h8000, 16'h7FFF, 1'b1, 32'hC0008000);
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] a, b;
      logic signed [15:0] sa, sb;
      logic s;
      longint ia, ib, pr;
      logic [63:0] pv;
      a = 16'($urandom); b = 16'($urandom); s = 1'($urandom_range(0, 1));
      sa = a; sb = b;
      ia = s ? longint'(sa) : longint'(a);
      ib = s ? longint'(sb) : longint'(b);
      pr = ia * ib;
      pv = pr;
      run16(a, b, s, pv[31:0]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/booth_mult_param.md
Name: booth_mult_param

Overview:
Parametrised iterative radix-2 Booth multiplier. It is the generalised successor of the team's fixed 8x8 signed multiplier.
- Adds a WIDTH parameter, a per-operation signed/unsigned mode and full valid/ready handshakes on both input and output, with output back-pressure.
- Sits between the operand-capture logic and the result display/consumer path; processes one operation at a time.

Parameters:
WIDTH, 8, operand width in bits (min 2); product is 2*WIDTH bits.
W1 (localparam), WIDTH+1, internal operand width after sign/zero extension; also the iteration count.
CW (localparam), $clog2(W1+1), iteration-counter width.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
valid  input  1  operand request; A, B, is_signed are sampled when valid && ready
ready  output  1  block can accept operands (high only in IDLE)
A  input  WIDTH  multiplicand
B  input  WIDTH  multiplier
is_signed  input  1  1 = two's-complement operands, 0 = unsigned
Mult  output  2*WIDTH  product, stable while done is high
done  output  1  result valid (held until acknowledged)
ack  input  1  consumer accepts result when done && ack

Behaviour:
Reset:
- rst sampled high at a rising edge: state = IDLE, ready = 1, done = 0, Mult = 0, counter = 0, datapath registers = 0.
- Reset overrides everything, including mid-CALC and DONE; the in-flight operation is discarded with no result.

FSM, states IDLE, CALC, DONE:
- IDLE: ready = 1. On valid && ready at an edge:
  - M = ext(A), Q = ext(B), acc = 0, q_1 = 0, cnt = 0; go to CALC.
  - ext() is sign-extension to W1 bits if is_signed, else zero-extension.
  - is_signed is latched for the operation.
- CALC: ready = 0. Each edge performs one Booth step on {Q[0], q_1}:
  - 01: acc += M
  - 10: acc -= M
  - 00/11: no change
  - Then arithmetic right shift of {acc, Q, q_1} by 1; cnt++.
  - When cnt reaches W1-1 at an edge, that edge performs the final step, loads Mult and goes to DONE.
- DONE: done = 1, Mult holds the product.
  - On done && ack at an edge: go to IDLE, done = 0.
  - Mult keeps its last value until the next result is loaded.

Timing:
- No acceptance occurs in the same cycle as the DONE->IDLE transition; ready rises the cycle after ack.
- Latency: acceptance at edge k, done = 1 after edge k+W1 (WIDTH=8: 9 cycles). Latency is fixed and independent of operand values.
- Throughput without back-pressure: one operation per W1+2 cycles.
- ack while not in DONE is ignored. valid while not in IDLE is ignored; operands are not queued.
- A, B and is_signed may change freely after acceptance.

Arithmetic:
- acc is W1+1 bits wide so that add/sub never overflow.
- Final product = {acc, Q} after W1 steps, truncated to the low 2*WIDTH bits.
- The result is exact for all signed and unsigned operand pairs (no overflow possible).

Decomposition:
Package booth_pkg:
- typedef enum logic [1:0] {IDLE, CALC, DONE} booth_state_t
- Booth-decode constants for 01/10.

Optional sub-module booth_step:
- Combinational one-iteration add/sub plus arithmetic shift, parametrised by W1.
- Instantiated once in booth_mult_param; can be unit-tested alone.
- The FSM, counter and handshake stay in the top module.

Test Plan:
1. WIDTH=8, rst then valid with A=4, B=7, is_signed=1, ack held high -> ready low the cycle after accept; done after exactly 9 cycles; Mult=16'h001C; ready returns high.
2. WIDTH=8, signed: A=-128, B=-128 -> Mult=16'h4000. A=-1, B=1 -> Mult=16'hFFFF. A=0, B=-77 -> Mult=16'h0000.
3. WIDTH=8, unsigned: A=255, B=255, is_signed=0 -> Mult=16'hFE01. Same bits with is_signed=1 (-1 * -1) -> Mult=16'h0001.
4. Back-pressure: ack=0 for 20 cycles after done -> done and Mult stay stable; valid pulses during this period are ignored; ack=1 for one cycle -> done falls; next operation gets its own result.
5. Reset mid-operation: assert rst for one cycle 4 cycles after accept -> state IDLE, done=0, Mult=0, ready=1 next cycle; a new op 3*5 then returns 15 with normal latency.
6. WIDTH=16 instance, signed: A=-32768, B=32767 -> done after 17 cycles, Mult=32'hC0008000. Also a randomized 1000-op self-check against $signed/$unsigned multiplication.
